// File: rtl/sne_evt_stream_pkg.sv
// Shared types for the SNE event stream: timestamps, event operations,
// the event record itself, and the state set of the time sequencer.
package sne_evt_stream_pkg;

    localparam int unsigned TS_WIDTH      = 8;
    localparam int unsigned PAYLOAD_WIDTH = 8;

    typedef struct packed {
        logic [TS_WIDTH-1:0] value;
    } timestamp_t;

    typedef enum logic [1:0] {
        EVT_SPIKE = 2'd0,
        EVT_TIME  = 2'd1,
        EVT_SYNCH = 2'd2
    } sne_op_e;

    typedef struct packed {
        sne_op_e                  operation;
        timestamp_t               timestamp;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } sne_evt_t;

    typedef enum logic [2:0] {
        IDLE,
        TIME,
        SYNCH,
        FWD,
        FLUSH
    } evt_seq_state_e;

    // Next timestamp of the step counter; all-ones wraps back to zero.
    function automatic timestamp_t tsIncrement(input timestamp_t ts);
        timestamp_t result;
        result.value = ts.value + 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/sne_event_stream.sv
// Valid/ready event stream carrying one sne_evt_t per handshake.
interface SNE_EVENT_STREAM;
    import sne_evt_stream_pkg::*;

    logic     valid;
    logic     ready;
    sne_evt_t evt;

    modport src (output valid, output evt, input ready);
    modport dst (input valid, input evt, output ready);

endinterface

// File: rtl/evt_time_sequencer.sv
// Splits the incoming spike stream into a time/synch stream and a spike
// stream. A spike from a new time step is held back until EVT_TIME (and
// optionally EVT_SYNCH) has been delivered, so global time settles first.
module evt_time_sequencer
    import sne_evt_stream_pkg::*;
#(
    parameter bit EMIT_INITIAL = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enable_i,
    input  logic         synch_en_i,
    input  logic         flush_i,
    output logic         flush_done_o,
    output timestamp_t   last_time_o,
    SNE_EVENT_STREAM.dst evt_stream_dst,
    SNE_EVENT_STREAM.src evt_stream_spike_src,
    SNE_EVENT_STREAM.src evt_stream_time_src
);

    evt_seq_state_e r_state;
    evt_seq_state_e w_next;
    sne_evt_t       r_hold;
    logic           r_synch;
    timestamp_t     r_last;
    logic           r_init;

    logic           w_isNew;
    logic           w_capture;
    logic           w_lastLoad;
    timestamp_t     w_lastNext;

    // A spike opens a new step on any timestamp change (wraps included),
    // and the very first spike after reset may be forced to open one.
    assign w_isNew = (evt_stream_dst.evt.timestamp.value != r_last.value)
                   || (!r_init && EMIT_INITIAL);

    assign last_time_o = r_last;

    // Next-state decode and all stream outputs; defaults keep every src quiet.
    always_comb begin
        w_next                     = r_state;
        w_capture                  = 1'b0;
        w_lastLoad                 = 1'b0;
        w_lastNext                 = r_last;
        flush_done_o               = 1'b0;
        evt_stream_dst.ready       = 1'b0;
        evt_stream_spike_src.valid = 1'b0;
        evt_stream_spike_src.evt   = r_hold;
        evt_stream_time_src.valid  = 1'b0;
        evt_stream_time_src.evt    = '0;

        case (r_state)
            IDLE: begin
                if (evt_stream_dst.valid && enable_i) begin
                    if (w_isNew) begin
                        evt_stream_dst.ready = 1'b1;
                        w_capture            = 1'b1;
                        w_next               = TIME;
                    end else begin
                        evt_stream_spike_src.valid = 1'b1;
                        evt_stream_spike_src.evt   = evt_stream_dst.evt;
                        evt_stream_dst.ready       = evt_stream_spike_src.ready;
                    end
                end else if (!evt_stream_dst.valid && flush_i) begin
                    w_next = FLUSH;
                end
            end
            TIME: begin
                evt_stream_time_src.valid             = 1'b1;
                evt_stream_time_src.evt.operation     = EVT_TIME;
                evt_stream_time_src.evt.timestamp     = r_hold.timestamp;
                if (evt_stream_time_src.ready) begin
                    w_lastLoad = 1'b1;
                    w_lastNext = r_hold.timestamp;
                    w_next     = r_synch ? SYNCH : FWD;
                end
            end
            SYNCH: begin
                evt_stream_time_src.valid             = 1'b1;
                evt_stream_time_src.evt.operation     = EVT_SYNCH;
                evt_stream_time_src.evt.timestamp     = r_last;
                if (evt_stream_time_src.ready) begin
                    w_next = FWD;
                end
            end
            FWD: begin
                evt_stream_spike_src.valid = 1'b1;
                if (evt_stream_spike_src.ready) begin
                    w_next = IDLE;
                end
            end
            FLUSH: begin
                evt_stream_time_src.valid             = 1'b1;
                evt_stream_time_src.evt.operation     = EVT_TIME;
                evt_stream_time_src.evt.timestamp     = tsIncrement(r_last);
                if (evt_stream_time_src.ready) begin
                    w_lastLoad   = 1'b1;
                    w_lastNext   = tsIncrement(r_last);
                    flush_done_o = 1'b1;
                    w_next       = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Hold the triggering spike and the synch choice for the whole sequence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold  <= '0;
            r_synch <= 1'b0;
        end else if (w_capture) begin
            r_hold  <= evt_stream_dst.evt;
            r_synch <= synch_en_i;
        end
    end

    // Track the last timestamp delivered on the time stream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= '0;
            r_init <= 1'b0;
        end else if (w_lastLoad) begin
            r_last <= w_lastNext;
            r_init <= 1'b1;
        end
    end

endmodule

// File: tb/tb_evt_time_sequencer.sv
// Scoreboard bench for evt_time_sequencer: stimulus pushes expected events
// from a step-level reference model, monitors pop and compare on handshakes.
module tb_evt_time_sequencer;
    import sne_evt_stream_pkg::*;

    localparam int LIMIT  = 400;
    localparam int TS_MOD = 1 << TS_WIDTH;

    typedef struct {
        sne_op_e op;
        int      ts;
        int      payload;
        bit      isFlush;
    } exp_evt_t;

    logic       clk      = 1'b0;
    logic       rstN     = 1'b0;
    logic       enable   = 1'b0;
    logic       synchEn  = 1'b0;
    logic       flushReq = 1'b0;
    logic       flushDone;
    timestamp_t lastTime;

    SNE_EVENT_STREAM inIf ();
    SNE_EVENT_STREAM spkIf ();
    SNE_EVENT_STREAM timeIf ();

    evt_time_sequencer #(.EMIT_INITIAL(1'b1)) dut (
        .clk_i                (clk),
        .rst_ni               (rstN),
        .enable_i             (enable),
        .synch_en_i           (synchEn),
        .flush_i              (flushReq),
        .flush_done_o         (flushDone),
        .last_time_o          (lastTime),
        .evt_stream_dst       (inIf),
        .evt_stream_spike_src (spkIf),
        .evt_stream_time_src  (timeIf)
    );

    always #5 clk = ~clk;

    exp_evt_t expTime[$];
    exp_evt_t expSpike[$];
    int       errors = 0;
    int       checks = 0;
    int       modelLast = 0;
    bit       modelInit = 1'b0;
    int       timeReadyMode = 1;
    int       spkReadyMode = 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got event/timeout expected none", name);
    endfunction

    // Reference model: a spike opens a step when its time differs from the
    // last announced one (or nothing was announced since reset).
    function automatic void modelSpike(input int ts, input int payload, input bit synch);
        exp_evt_t e;
        if (ts != modelLast || !modelInit) begin
            e = '{op: EVT_TIME, ts: ts, payload: 0, isFlush: 1'b0};
            expTime.push_back(e);
            if (synch) begin
                e = '{op: EVT_SYNCH, ts: ts, payload: 0, isFlush: 1'b0};
                expTime.push_back(e);
            end
            modelLast = ts;
            modelInit = 1'b1;
        end
        e = '{op: EVT_SPIKE, ts: ts, payload: payload, isFlush: 1'b0};
        expSpike.push_back(e);
    endfunction

    function automatic void modelFlush();
        exp_evt_t e;
        modelLast = (modelLast + 1) % TS_MOD;
        modelInit = 1'b1;
        e = '{op: EVT_TIME, ts: modelLast, payload: 0, isFlush: 1'b1};
        expTime.push_back(e);
    endfunction

    task automatic waitFlushDone();
        bit seen = 1'b0;
        for (int c = 0; c < LIMIT && !seen; c++) begin
            @(negedge clk);
            if (flushDone) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        flushReq = 1'b0;
        if (!seen) fail("flush_done_timeout");
    endtask

    task automatic applyStimulus(input int ts, input int payload, input bit synch,
                                 input bit withFlush, output int lat);
        bit accepted = 1'b0;
        modelSpike(ts, payload, synch);
        if (withFlush) modelFlush();
        lat = -1;
        @(posedge clk);
        #1;
        inIf.valid                     = 1'b1;
        inIf.evt.operation             = EVT_SPIKE;
        inIf.evt.timestamp.value       = ts[TS_WIDTH-1:0];
        inIf.evt.payload               = payload[PAYLOAD_WIDTH-1:0];
        synchEn                        = synch;
        if (withFlush) flushReq = 1'b1;
        for (int c = 0; c < LIMIT && !accepted; c++) begin
            @(negedge clk);
            if (inIf.ready) begin
                accepted = 1'b1;
                lat      = c;
            end
        end
        @(posedge clk);
        #1;
        inIf.valid = 1'b0;
        if (!accepted) fail("accept_timeout");
        if (withFlush) waitFlushDone();
    endtask

    task automatic applyFlush();
        modelFlush();
        @(posedge clk);
        #1;
        flushReq = 1'b1;
        waitFlushDone();
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rstN       = 1'b0;
        inIf.valid = 1'b0;
        flushReq   = 1'b0;
        expTime.delete();
        expSpike.delete();
        modelLast = 0;
        modelInit = 1'b0;
        @(negedge clk);
        check("rst_spike_valid", spkIf.valid, 0);
        check("rst_time_valid", timeIf.valid, 0);
        check("rst_flush_done", flushDone, 0);
        check("rst_last_time", lastTime.value, 0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic checkOutput(input string name);
        for (int c = 0; c < LIMIT && (expTime.size() != 0 || expSpike.size() != 0); c++) begin
            @(negedge clk);
        end
        if (expTime.size() != 0 || expSpike.size() != 0) fail({name, "_drain_timeout"});
        repeat (2) @(negedge clk);
        check({name, "_last_time"}, lastTime.value, modelLast);
    endtask

    // Monitors, ready generators and the directed/random stimulus sequence.
    initial begin
        int       lat;
        bit       found;
        sne_evt_t tPrev;
        sne_evt_t sPrev;
        bit       tStall;
        bit       sStall;
        exp_evt_t e;

        inIf.valid   = 1'b0;
        inIf.evt     = '0;
        timeIf.ready = 1'b1;
        spkIf.ready  = 1'b1;
        tStall       = 1'b0;
        sStall       = 1'b0;
        tPrev        = '0;
        sPrev        = '0;

        fork
            forever begin
                @(posedge clk);
                #1;
                timeIf.ready = (timeReadyMode == 2) ? ($urandom_range(0, 3) != 0) : (timeReadyMode == 1);
                spkIf.ready  = (spkReadyMode == 2) ? ($urandom_range(0, 3) != 0) : (spkReadyMode == 1);
            end
            forever begin
                @(negedge clk);
                if (!rstN) begin
                    tStall = 1'b0;
                    sStall = 1'b0;
                end else begin
                    if (tStall) begin
                        check("time_hold_valid", timeIf.valid, 1);
                        check("time_hold_data", timeIf.evt, tPrev);
                    end
                    if (sStall) begin
                        check("spike_hold_valid", spkIf.valid, 1);
                        check("spike_hold_data", spkIf.evt, sPrev);
                    end
                    if (timeIf.valid && timeIf.ready) begin
                        if (expTime.size() == 0) begin
                            fail("time_unexpected");
                        end else begin
                            e = expTime.pop_front();
                            check("time_op", timeIf.evt.operation, e.op);
                            check("time_ts", timeIf.evt.timestamp.value, e.ts);
                            check("flush_done", flushDone, e.isFlush);
                        end
                    end else if (flushDone) begin
                        check("flush_done_stray", flushDone, 0);
                    end
                    if (spkIf.valid && spkIf.ready) begin
                        if (expSpike.size() == 0) begin
                            fail("spike_unexpected");
                        end else begin
                            e = expSpike.pop_front();
                            check("spike_op", spkIf.evt.operation, e.op);
                            check("spike_ts", spkIf.evt.timestamp.value, e.ts);
                            check("spike_payload", spkIf.evt.payload, e.payload);
                        end
                    end
                    tStall = timeIf.valid && !timeIf.ready;
                    sStall = spkIf.valid && !spkIf.ready;
                    tPrev  = timeIf.evt;
                    sPrev  = spkIf.evt;
                end
            end
            begin
                #2000000;
                $display("[TB] FAIL watchdog: got timeout expected completion");
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        applyReset();
        enable = 1'b1;

        $display("[TB] new step ts=5 without synch");
        applyStimulus(5, 8'h11, 1'b0, 1'b0, lat);
        check("new_accept_latency", lat, 0);
        @(negedge clk);
        check("time_cycle1_valid", timeIf.valid, 1);
        check("time_cycle1_op", timeIf.evt.operation, EVT_TIME);
        @(negedge clk);
        check("spike_cycle2_valid", spkIf.valid, 1);
        checkOutput("ts5");

        $display("[TB] same-step pass-through");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5, 8'h20 + i, 1'b0, 1'b0, lat);
            check("passthru_latency", lat, 0);
            check("passthru_same_cycle", expSpike.size(), 0);
        end
        checkOutput("passthru");

        $display("[TB] synch with time backpressure");
        @(negedge clk);
        timeReadyMode = 0;
        applyStimulus(6, 8'h33, 1'b1, 1'b0, lat);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_time_valid", timeIf.valid, 1);
            check("stall_time_op", timeIf.evt.operation, EVT_TIME);
            check("stall_time_ts", timeIf.evt.timestamp.value, 6);
        end
        timeReadyMode = 1;
        checkOutput("synch6");

        $display("[TB] flush wraps from all-ones");
        applyStimulus(TS_MOD - 1, 8'h44, 1'b0, 1'b0, lat);
        checkOutput("ts_max");
        applyFlush();
        checkOutput("flush_wrap");

        $display("[TB] spike and flush in the same cycle");
        applyStimulus(9, 8'h55, 1'b0, 1'b1, lat);
        checkOutput("spike_then_flush");

        $display("[TB] enable low blocks acceptance");
        @(posedge clk);
        #1;
        enable                   = 1'b0;
        inIf.valid               = 1'b1;
        inIf.evt.operation       = EVT_SPIKE;
        inIf.evt.timestamp.value = 8'd77;
        inIf.evt.payload         = 8'h66;
        repeat (3) begin
            @(negedge clk);
            check("disabled_ready", inIf.ready, 0);
            check("disabled_spike_valid", spkIf.valid, 0);
            check("disabled_time_valid", timeIf.valid, 0);
        end
        @(posedge clk);
        #1;
        inIf.valid = 1'b0;
        enable     = 1'b1;

        $display("[TB] reset while in SYNCH");
        @(negedge clk);
        timeReadyMode = 0;
        applyStimulus(20, 8'h77, 1'b1, 1'b0, lat);
        found = 1'b0;
        for (int c = 0; c < LIMIT && !found; c++) begin
            @(negedge clk);
            if (timeIf.valid && timeIf.evt.operation == EVT_TIME) found = 1'b1;
        end
        if (!found) fail("reach_time_timeout");
        timeReadyMode = 1;
        @(negedge clk);
        timeReadyMode = 0;
        @(negedge clk);
        check("in_synch_valid", timeIf.valid, 1);
        check("in_synch_op", timeIf.evt.operation, EVT_SYNCH);
        applyReset();
        timeReadyMode = 1;
        applyStimulus(0, 8'h88, 1'b0, 1'b0, lat);
        checkOutput("post_reset_ts0");

        $display("[TB] randomized traffic with backpressure");
        timeReadyMode = 2;
        spkReadyMode  = 2;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                applyFlush();
            end else if ($urandom_range(0, 2) == 0) begin
                applyStimulus($urandom_range(0, TS_MOD - 1), $urandom_range(0, 255),
                              1'($urandom_range(0, 1)), 1'b0, lat);
            end else begin
                applyStimulus(modelLast, $urandom_range(0, 255),
                              1'($urandom_range(0, 1)), 1'b0, lat);
            end
        end
        checkOutput("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
